instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/mips_pkg.sv | 32 +++
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch path.
// Holds the default widths, the fetch FSM state type and the byte-lane packing helper.
package mips_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_ISSUE = 2'd1,
        FS_DRAIN = 2'd2,
        FS_DONE  = 2'd3
    } fetch_state_e;

    // Only lanes 0..2 are stored; lane 3 goes straight from the memory bus into the instruction.
    function automatic logic [23:0] put_byte(
        input logic [23:0] acc,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [23:0] res;
        res = acc;
        case (idx)
            2'd0:    res[7:0]   = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[23:16] = b;
            default: res        = acc;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetches one 32-bit little-endian instruction from a byte-wide synchronous memory.
// The memory returns data one cycle after it samples the address.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_i,
    input  logic [31:0]        pc_i,
    input  logic               flush_i,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [7:0]         mem_rdata_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               err_o
);

    fetch_state_e       r_state;
    logic [1:0]         r_cnt;
    logic [ADDR_W-3:0]  r_base_hi;
    logic [23:0]        r_bytes;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_busy;
    logic               r_err;

    logic               w_misaligned;
    logic [1:0]         w_cnt_inc;
    logic [1:0]         w_lane;
    logic [31:0]        w_assembled;
    logic               w_unused_pc;

    assign w_misaligned = (pc_i[1:0] != 2'b00);
    assign w_cnt_inc    = r_cnt + 2'd1;
    assign w_lane       = r_cnt - 2'd1;
    assign w_assembled  = {mem_rdata_i, r_bytes};
    assign w_unused_pc  = ^pc_i[31:ADDR_W];

    // Fetch sequencer: issues base+0..3, captures each byte two edges after its address.
    // DONE also acts as an accept window so back-to-back fetches start six edges apart.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= FS_IDLE;
            r_cnt      <= 2'd0;
            r_base_hi  <= '0;
            r_bytes    <= 24'd0;
            r_mem_addr <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                FS_IDLE, FS_DONE: begin
                    if (flush_i || !req_i) begin
                        r_state <= FS_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_misaligned) begin
                        r_state <= FS_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_state    <= FS_ISSUE;
                        r_busy     <= 1'b1;
                        r_cnt      <= 2'd0;
                        r_bytes    <= 24'd0;
                        r_base_hi  <= pc_i[ADDR_W-1:2];
                        r_mem_addr <= {pc_i[ADDR_W-1:2], 2'b00};
                    end
                end
                FS_ISSUE: begin
                    if (flush_i) begin
                        r_state <= FS_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_bytes <= 24'd0;
                    end else begin
                        r_mem_addr <= {r_base_hi, w_cnt_inc};
                        r_cnt      <= w_cnt_inc;
                        if (r_cnt != 2'd0) begin
                            r_bytes <= put_byte(r_bytes, w_lane, mem_rdata_i);
                        end else begin
                            r_bytes <= r_bytes;
                        end
                        if (r_cnt == 2'd2) begin
                            r_state <= FS_DRAIN;
                        end else begin
                            r_state <= FS_ISSUE;
                        end
                    end
                end
                FS_DRAIN: begin
                    if (flush_i) begin
                        r_state <= FS_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 2'd0;
                        r_bytes <= 24'd0;
                    end else if (r_cnt == 2'd0) begin
                        r_instr <= INSTR_W'(w_assembled);
                        r_valid <= 1'b1;
                        r_state <= FS_DONE;
                    end else begin
                        r_bytes <= put_byte(r_bytes, w_lane, mem_rdata_i);
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 2'd0;
                end
            endcase
        end
    end

    assign mem_addr_o = r_mem_addr;
    assign instr_o    = r_instr;
    assign valid_o    = r_valid;
    assign busy_o     = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a byte-array memory and
// an expected-word model computed arithmetically from that array.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] instr;
    logic        valid;
    logic        busy;
    logic        err;

    logic [7:0]  mem [0:63];
    logic [31:0] exp_instr;
    logic [31:0] exp_addr;
    int          n_pass;
    int          n_total;

    instr_fetch #(.ADDR_W(6), .INSTR_W(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .pc_i        (pc),
        .flush_i     (flush),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .instr_o     (instr),
        .valid_o     (valid),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory: data appears one cycle after the address is sampled.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    function automatic logic [31:0] ref_word(input int b);
        return 32'(mem[b + 3]) * 32'd16777216 + 32'(mem[b + 2]) * 32'd65536
             + 32'(mem[b + 1]) * 32'd256 + 32'(mem[b]);
    endfunction

    task automatic load_word(input int b, input logic [31:0] w);
        mem[b]     = w[7:0];
        mem[b + 1] = w[15:8];
        mem[b + 2] = w[23:16];
        mem[b + 3] = w[31:24];
    endtask

    // One complete fetch starting at the next edge (E0); hold keeps req high with next_pc.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_word,
                         input string tag, input bit hold, input logic [31:0] next_pc);
        int base;
        int kmax;
        base = int'(addr[5:0]);
        kmax = hold ? 5 : 6;
        req  = 1'b1;
        pc   = addr;
        for (int k = 0; k <= kmax; k++) begin
            step();
            if (hold) pc = next_pc;
            else req = 1'b0;
            if (k == 5) exp_instr = exp_word;
            chk($sformatf("%s/k%0d/addr", tag, k), 32'(mem_addr), 32'(base + ((k > 3) ? 3 : k)));
            chk($sformatf("%s/k%0d/busy", tag, k), 32'(busy), 32'(k <= 5));
            chk($sformatf("%s/k%0d/valid", tag, k), 32'(valid), 32'(k == 5));
            chk($sformatf("%s/k%0d/instr", tag, k), instr, exp_instr);
            chk($sformatf("%s/k%0d/err", tag, k), 32'(err), 32'd0);
        end
        exp_addr = 32'(base + 3);
    endtask

    task automatic idle_chk(input string tag, input logic exp_err);
        chk({tag, "/err"}, 32'(err), 32'(exp_err));
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/valid"}, 32'(valid), 32'd0);
        chk({tag, "/addr"}, 32'(mem_addr), exp_addr);
        chk({tag, "/instr"}, instr, exp_instr);
    endtask

    initial begin
        logic [31:0] a;
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        req       = 1'b0;
        flush     = 1'b0;
        pc        = 32'd0;
        exp_instr = 32'd0;
        exp_addr  = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        load_word(0, 32'h20030008);
        load_word(4, 32'h20040001);
        load_word(28, 32'h08000003);
        load_word(32, 32'hA00400FF);

        step();
        step();
        idle_chk("reset", 1'b0);
        rst_n = 1'b1;

        fetch(32'h00, 32'h20030008, "fib_pc00", 1'b0, 32'd0);
        fetch(32'h20, 32'hA00400FF, "fib_pc20", 1'b0, 32'd0);
        fetch(32'h1C, 32'h08000003, "fib_pc1c", 1'b0, 32'd0);
        fetch(32'h3C, ref_word(60), "top_pc3c", 1'b0, 32'd0);

        req = 1'b1;
        pc  = 32'h3E;
        step();
        req = 1'b0;
        idle_chk("misalign", 1'b1);
        step();
        idle_chk("misalign_after", 1'b0);

        req = 1'b1;
        pc  = 32'h08;
        step();
        req = 1'b0;
        chk("flush/e0_busy", 32'(busy), 32'd1);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush/busy", 32'(busy), 32'd0);
        chk("flush/valid", 32'(valid), 32'd0);
        chk("flush/instr", instr, exp_instr);
        fetch(32'h04, 32'h20040001, "after_flush", 1'b0, 32'd0);

        req   = 1'b1;
        flush = 1'b1;
        pc    = 32'h10;
        step();
        req   = 1'b0;
        flush = 1'b0;
        idle_chk("flush_req_idle", 1'b0);

        req = 1'b1;
        pc  = 32'h0C;
        step();
        req = 1'b0;
        step();
        rst_n = 1'b0;
        req   = 1'b1;
        flush = 1'b1;
        step();
        exp_instr = 32'd0;
        exp_addr  = 32'd0;
        idle_chk("mid_reset", 1'b0);
        rst_n = 1'b1;
        req   = 1'b0;
        flush = 1'b0;
        step();
        idle_chk("post_reset", 1'b0);

        fetch(32'h10, ref_word(16), "held_a", 1'b1, 32'h24);
        fetch(32'h24, ref_word(36), "held_b", 1'b0, 32'd0);

        for (int r = 0; r < 6; r++) begin
            a = 32'($urandom_range(0, 15)) * 32'd4;
            fetch(a, ref_word(int'(a)), $sformatf("rnd%0d", r), 1'b0, 32'd0);
        end

        a   = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
        req = 1'b1;
        pc  = a;
        step();
        req = 1'b0;
        idle_chk("rnd_misalign", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
